rgb_dither: RTL and testbench

//  Parametrised colour-depth reducer between video generator and the resistor-DAC pins.

---
 rtl/rgb_dither.sv | 139 +++++++++++++
 tb/tb_rgb_dither.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rgb_dither.sv
// Colour-depth reducer with 2x2 ordered (Bayer) dither feeding the resistor-DAC pins.
// Define RGB_DITHER_FRAME_ROT_EN to rotate the pattern each frame (temporal dither).
module rgb_dither #(
  parameter int unsigned R_IN_W = 3,
  parameter int unsigned G_IN_W = 3,
  parameter int unsigned B_IN_W = 2,
  parameter int unsigned OUT_W  = 2
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic              strobe,
  input  logic              up_en,
  input  logic              blank,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [R_IN_W-1:0] r_i,
  input  logic [G_IN_W-1:0] g_i,
  input  logic [B_IN_W-1:0] b_i,
  output logic [OUT_W-1:0]  r_o,
  output logic [OUT_W-1:0]  g_o,
  output logic [OUT_W-1:0]  b_o
);

  localparam int unsigned TotW = R_IN_W + G_IN_W + B_IN_W;

  logic       hs_d_q, vs_d_q;
  logic       hs_rise, vs_rise;
  logic       pix_ph_q, line_ph_q;
  logic [1:0] frame_ph;
  logic [1:0] bayer, rank;

  assign hs_rise = hsync & ~hs_d_q;
  assign vs_rise = vsync & ~vs_d_q;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      hs_d_q    <= 1'b0;
      vs_d_q    <= 1'b0;
      pix_ph_q  <= 1'b0;
      line_ph_q <= 1'b0;
    end else begin
      hs_d_q <= hsync;
      vs_d_q <= vsync;
      if (hs_rise)     pix_ph_q <= 1'b0;
      else if (strobe) pix_ph_q <= ~pix_ph_q;
      if (vs_rise)      line_ph_q <= 1'b0;
      else if (hs_rise) line_ph_q <= ~line_ph_q;
    end
  end

`ifdef RGB_DITHER_FRAME_ROT_EN
  logic [1:0] frame_ph_q;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n)       frame_ph_q <= 2'd0;
    else if (vs_rise) frame_ph_q <= frame_ph_q + 2'd1;
  end

  assign frame_ph = frame_ph_q;
`else
  assign frame_ph = 2'd0;
`endif

  always_comb begin
    bayer = 2'd0;
    unique case ({line_ph_q, pix_ph_q})
      2'b00: bayer = 2'd0;
      2'b01: bayer = 2'd2;
      2'b10: bayer = 2'd3;
      2'b11: bayer = 2'd1;
      default: bayer = 2'd0;
    endcase
  end

  // Wraps naturally mod 4.
  assign rank = bayer + frame_ph;

  logic [TotW-1:0]  in_all;
  logic [OUT_W-1:0] out_d [3];
  logic [OUT_W-1:0] out_q [3];

  assign in_all = {b_i, g_i, r_i};

  for (genvar c = 0; c < 3; c++) begin : g_ch
    localparam int W   = (c == 0) ? R_IN_W : (c == 1) ? G_IN_W : B_IN_W;
    localparam int Off = (c == 0) ? 0 : (c == 1) ? R_IN_W : R_IN_W + G_IN_W;
    localparam int D   = W - int'(OUT_W);

    logic [W-1:0]     in_c;
    logic [OUT_W-1:0] trunc;
    logic [OUT_W-1:0] dith;

    assign in_c = in_all[Off +: W];

    if (D <= 0) begin : g_rep
      // Replicate MSB-first so full-scale input maps to full-scale output.
      always_comb begin
        trunc = '0;
        for (int k = 0; k < int'(OUT_W); k++) begin
          trunc[OUT_W-1-k] = in_c[W-1-(k % W)];
        end
      end
      assign dith = trunc;
    end else begin : g_dith
      logic [1:0] fs;
      logic       bump;

      assign trunc = in_c[W-1:D];
      if (D == 1) begin : g_fs1
        assign fs = {in_c[0], 1'b0};
      end else begin : g_fsn
        assign fs = in_c[D-1:D-2];
      end
      // Saturate: an all-ones base is never bumped.
      assign bump = (fs > rank) && (trunc != {OUT_W{1'b1}});
      assign dith = trunc + OUT_W'(bump);
    end

    always_comb begin
      out_d[c] = '0;
      if (blank)      out_d[c] = '0;
      else if (up_en) out_d[c] = dith;
      else            out_d[c] = trunc;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) out_q[c] <= '0;
    end else begin
      for (int c = 0; c < 3; c++) out_q[c] <= out_d[c];
    end
  end

  assign r_o = out_q[0];
  assign g_o = out_q[1];
  assign b_o = out_q[2];

endmodule

// File: tb/tb_rgb_dither.sv
// Directed self-checking bench for rgb_dither at default widths (3/3/2 -> 2).
// Walks the 2x2 Bayer positions, sync priorities, passthrough, blank and async reset.
module tb_rgb_dither;

  logic       clk28 = 1'b0;
  logic       rst_n, strobe, up_en, blank, hsync, vsync;
  logic [2:0] r_i, g_i;
  logic [1:0] b_i;
  logic [1:0] r_o, g_o, b_o;

  int checks = 0;
  int errors = 0;

  always #18 clk28 = ~clk28;

  rgb_dither #(
    .R_IN_W(3),
    .G_IN_W(3),
    .B_IN_W(2),
    .OUT_W (2)
  ) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .strobe(strobe),
    .up_en (up_en),
    .blank (blank),
    .hsync (hsync),
    .vsync (vsync),
    .r_i   (r_i),
    .g_i   (g_i),
    .b_i   (b_i),
    .r_o   (r_o),
    .g_o   (g_o),
    .b_o   (b_o)
  );

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [1:0] er, input logic [1:0] eg,
                           input logic [1:0] eb);
    check({tag, ".r"}, r_o, er);
    check({tag, ".g"}, g_o, eg);
    check({tag, ".b"}, b_o, eb);
  endtask

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  // Each pulse ends with one idle cycle so outputs reflect the new phases.
  task automatic strobe_pulse();
    strobe = 1'b1; tick();
    strobe = 1'b0; tick();
  endtask

  task automatic hs_pulse();
    hsync = 1'b1; tick();
    hsync = 1'b0; tick();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
  endtask

  initial begin
    rst_n = 1'b0; strobe = 1'b0; up_en = 1'b1; blank = 1'b0;
    hsync = 1'b0; vsync = 1'b0;
    r_i = 3'b111; g_i = 3'b001; b_i = 2'b10;
    tick(); tick();
    check_rgb("reset", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    tick();

    // Position walk: (line,pix) 00 rank0, 01 rank2, 10 rank3, 11 rank1.
    check_rgb("pos00", 2'b11, 2'b01, 2'b10);
    strobe_pulse();
    check_rgb("pos01", 2'b11, 2'b00, 2'b10);
    hs_pulse();
    check_rgb("pos10", 2'b11, 2'b00, 2'b10);
    strobe_pulse();
    check_rgb("pos11", 2'b11, 2'b01, 2'b10);

    // Red dither at rank1: 101 -> base 10 fs 2 -> 11; 100 -> fs 0 -> 10.
    r_i = 3'b101; tick();
    check("r101_rank1", r_o, 2'b11);
    r_i = 3'b100; tick();
    check("r100_rank1", r_o, 2'b10);
    r_i = 3'b111;

    // hs_rise beats strobe: from (1,1) go to (0,0), then hs+strobe -> (1,0).
    hs_pulse();
    check("hs_to_00", g_o, 2'b01);
    strobe = 1'b1; hsync = 1'b1; tick();
    strobe = 1'b0; hsync = 1'b0; tick();
    check("hs_beats_strobe", g_o, 2'b00);

    // vs_rise beats hs_rise: from (0,0), vs+hs must leave line_ph at 0.
    hs_pulse();
    check("hs_to_00b", g_o, 2'b01);
    vsync = 1'b1; hsync = 1'b1; tick();
    vsync = 1'b0; hsync = 1'b0; tick();
    check("vs_beats_hs", g_o, 2'b01);

    // Passthrough truncation.
    up_en = 1'b0;
    g_i = 3'b101; tick();
    check_rgb("pass101", 2'b11, 2'b10, 2'b10);
    g_i = 3'b001; tick();
    check("pass001_nodither", g_o, 2'b00);
    up_en = 1'b1; tick();
    check("dither_back", g_o, 2'b01);

    // Blank overrides, one cycle latency.
    blank = 1'b1; tick();
    check_rgb("blank", 2'b00, 2'b00, 2'b00);
    blank = 1'b0; tick();
    check_rgb("unblank", 2'b11, 2'b01, 2'b10);

    // Mid-line async reset with pix_ph=1.
    strobe_pulse();
    check("pre_reset_pos01", g_o, 2'b00);
    #5 rst_n = 1'b0;
    #1;
    check_rgb("async_reset", 2'b00, 2'b00, 2'b00);
    tick();
    check_rgb("reset_held", 2'b00, 2'b00, 2'b00);
    #5 rst_n = 1'b1;
    tick();
    check_rgb("post_reset_rank0", 2'b11, 2'b01, 2'b10);

    // Frame rotation at (0,0): ranks 0,1,2,3,0 with the macro; static rank 0 without.
`ifdef RGB_DITHER_FRAME_ROT_EN
    vs_pulse(); check("frame1", g_o, 2'b01);
    vs_pulse(); check("frame2", g_o, 2'b00);
    vs_pulse(); check("frame3", g_o, 2'b00);
    vs_pulse(); check("frame4", g_o, 2'b01);
`else
    vs_pulse(); check("frame1", g_o, 2'b01);
    vs_pulse(); check("frame2", g_o, 2'b01);
    vs_pulse(); check("frame3", g_o, 2'b01);
    vs_pulse(); check("frame4", g_o, 2'b01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
